// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : Valid/ready sequencer for a shared 8-bit ALU; iterates the add
//            path for an 8x8 shift-add multiply when ALU_SEQ_MUL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_op,
   input  logic [WIDTH-1:0]     req_a,
   input  logic [WIDTH-1:0]     req_b,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [1:0]           alu_sel,
   input  logic [WIDTH-1:0]     alu_out,
   input  logic                 alu_cout,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [2*WIDTH-1:0]   rsp_data,
   output logic                 rsp_err,
   output logic                 busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_AND  = 2'b11;

   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_AND = 2'b10;

   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [1:0]          op;
   logic                exec_done;

   logic [WIDTH-1:0]    alu_a_nxt;
   logic [WIDTH-1:0]    alu_b_nxt;
   logic [1:0]          alu_sel_nxt;
   logic                rsp_valid_nxt;
   logic [2*WIDTH-1:0]  rsp_data_nxt;
   logic                rsp_err_nxt;

`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0]    m;
   logic [WIDTH-1:0]    p_hi;
   logic [WIDTH-1:0]    p_lo;
   logic [2:0]          cnt;
   logic [WIDTH-1:0]    m_nxt;
   logic [WIDTH-1:0]    p_hi_nxt;
   logic [WIDTH-1:0]    p_lo_nxt;
   logic [2:0]          cnt_nxt;

   assign exec_done = (op != OP_MUL) || (cnt == 3'd7);
`else
   assign exec_done = 1'b1;
`endif

   assign req_ready = (state == ST_IDLE);
   assign busy      = (state == ST_EXEC) || (state == ST_RESP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_valid)  state_nxt = ST_EXEC;
         ST_EXEC: if (exec_done)  state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready)  state_nxt = ST_IDLE;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; ALU operands are registered, so
   // each cycle prepares the operands for the following EXEC cycle.
   always_comb begin
      alu_a_nxt     = '0;
      alu_b_nxt     = '0;
      alu_sel_nxt   = SEL_ADD;
      rsp_valid_nxt = (state_nxt == ST_RESP);
      rsp_data_nxt  = rsp_data;
      rsp_err_nxt   = rsp_err;
`ifdef ALU_SEQ_MUL_EN
      m_nxt         = m;
      p_hi_nxt      = p_hi;
      p_lo_nxt      = p_lo;
      cnt_nxt       = cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               case (req_op)
                  OP_ADD: begin
                     alu_a_nxt   = req_a;
                     alu_b_nxt   = req_b;
                     alu_sel_nxt = SEL_ADD;
                  end
                  OP_SUB: begin
                     alu_a_nxt   = req_a;
                     alu_b_nxt   = req_b;
                     alu_sel_nxt = SEL_SUB;
                  end
                  OP_AND: begin
                     alu_a_nxt   = req_a;
                     alu_b_nxt   = req_b;
                     alu_sel_nxt = SEL_AND;
                  end
                  default: begin
`ifdef ALU_SEQ_MUL_EN
                     m_nxt     = req_b;
                     p_hi_nxt  = '0;
                     p_lo_nxt  = req_a;
                     cnt_nxt   = 3'd0;
                     alu_b_nxt = req_a[0] ? req_b : '0;
`endif
                  end
               endcase
            end
         end
         ST_EXEC: begin
            case (op)
               OP_ADD, OP_SUB: begin
                  rsp_data_nxt = {{(WIDTH-1){1'b0}}, alu_cout, alu_out};
                  rsp_err_nxt  = 1'b0;
               end
               OP_AND: begin
                  rsp_data_nxt = {{WIDTH{1'b0}}, alu_out};
                  rsp_err_nxt  = 1'b0;
               end
               default: begin
`ifdef ALU_SEQ_MUL_EN
                  p_hi_nxt = {alu_cout, alu_out[WIDTH-1:1]};
                  p_lo_nxt = {alu_out[0], p_lo[WIDTH-1:1]};
                  cnt_nxt  = cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     rsp_data_nxt = {p_hi_nxt, p_lo_nxt};
                     rsp_err_nxt  = 1'b0;
                  end else begin
                     alu_a_nxt = p_hi_nxt;
                     alu_b_nxt = p_lo_nxt[0] ? m : '0;
                  end
`else
                  rsp_data_nxt = '0;
                  rsp_err_nxt  = 1'b1;
`endif
               end
            endcase
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op        <= OP_ADD;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= SEL_ADD;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         m         <= '0;
         p_hi      <= '0;
         p_lo      <= '0;
         cnt       <= 3'd0;
`endif
      end else begin
         if ((state == ST_IDLE) && req_valid) begin
            op <= req_op;
         end
         alu_a     <= alu_a_nxt;
         alu_b     <= alu_b_nxt;
         alu_sel   <= alu_sel_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_data  <= rsp_data_nxt;
         rsp_err   <= rsp_err_nxt;
`ifdef ALU_SEQ_MUL_EN
         m         <= m_nxt;
         p_hi      <= p_hi_nxt;
         p_lo      <= p_lo_nxt;
         cnt       <= cnt_nxt;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Purpose  : Table-driven self-checking bench for alu_seq_ctrl with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [7:0]  req_a;
   logic [7:0]  req_b;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [1:0]  alu_sel;
   logic [7:0]  alu_out;
   logic        alu_cout;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int passed = 0;
   int total  = 0;

   alu_seq_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .alu_cout  (alu_cout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference ALU: add, sub (carry = no borrow), and, or
   always_comb begin
      {alu_cout, alu_out} = 9'h000;
      case (alu_sel)
         2'b00: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         2'b01: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
         2'b10: {alu_cout, alu_out} = {1'b0, alu_a & alu_b};
         default: {alu_cout, alu_out} = {1'b0, alu_a | alu_b};
      endcase
   end

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] data;
      logic        err;
      int          lat;
      logic [1:0]  sel;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      req_op    = v.op;
      req_a     = v.a;
      req_b     = v.b;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      chk("exec_sel", {30'd0, alu_sel}, {30'd0, v.sel});
      chk("exec_alu_a", {24'd0, alu_a}, (v.op == 2'b10) ? 32'd0 : {24'd0, v.a});
      chk("busy_exec", {31'd0, busy}, 32'd1);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         if (v.op == 2'b10) chk("mul_sel", {30'd0, alu_sel}, 32'd0);
         tick();
         lat++;
      end
      chk("latency", lat, v.lat);
      chk("rsp_data", {16'd0, rsp_data}, {16'd0, v.data});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.err});
      tick();
      chk("req_ready_after", {31'd0, req_ready}, 32'd1);
      chk("rsp_valid_fall", {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_data"}, {16'd0, rsp_data}, 32'd0);
      chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
      chk({tag, "_alu_ab"}, {16'd0, alu_a, alu_b}, 32'd0);
      chk({tag, "_alu_sel"}, {30'd0, alu_sel}, 32'd0);
   endtask

   initial begin
      int lat;
      logic mul_en;
`ifdef ALU_SEQ_MUL_EN
      mul_en = 1'b1;
`else
      mul_en = 1'b0;
`endif
      vecs[0] = '{2'b00, 8'hF0, 8'h20, 16'h0110, 1'b0, 2, 2'b00};
      vecs[1] = '{2'b01, 8'h05, 8'h07, 16'h00FE, 1'b0, 2, 2'b01};
      vecs[2] = '{2'b01, 8'h07, 8'h05, 16'h0102, 1'b0, 2, 2'b01};
      vecs[3] = '{2'b11, 8'hA5, 8'h3C, 16'h0024, 1'b0, 2, 2'b10};
      vecs[4] = '{2'b00, 8'hFF, 8'h01, 16'h0100, 1'b0, 2, 2'b00};
      if (mul_en) begin
         vecs[5] = '{2'b10, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 9, 2'b00};
         vecs[6] = '{2'b10, 8'h00, 8'h9C, 16'h0000, 1'b0, 9, 2'b00};
         vecs[7] = '{2'b10, 8'h0D, 8'h0B, 16'h008F, 1'b0, 9, 2'b00};
      end else begin
         vecs[5] = '{2'b10, 8'hFF, 8'hFF, 16'h0000, 1'b1, 2, 2'b00};
         vecs[6] = '{2'b10, 8'h03, 8'h04, 16'h0000, 1'b1, 2, 2'b00};
         vecs[7] = '{2'b10, 8'h0D, 8'h0B, 16'h0000, 1'b1, 2, 2'b00};
      end
      vecs[8] = '{2'b00, 8'h12, 8'h34, 16'h0046, 1'b0, 2, 2'b00};
      vecs[9] = '{2'b11, 8'hFF, 8'h0F, 16'h000F, 1'b0, 2, 2'b10};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_a     = 8'h00;
      req_b     = 8'h00;
      rsp_ready = 1'b0;
      tick();
      tick();
      chk_reset_state("reset");
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // AND held in RESP by backpressure; a second request must wait
      req_op = 2'b11; req_a = 8'hA5; req_b = 8'h3C;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      tick();
      req_op = 2'b00; req_a = 8'h01; req_b = 8'h01;
      wait_rsp(lat);
      chk("bp_latency", lat, 2);
      for (int k = 0; k < 3; k++) begin
         chk("bp_data_stable", {16'd0, rsp_data}, 32'h0024);
         chk("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
         chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
      chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      req_valid = 1'b0;
      wait_rsp(lat);
      chk("held_req_latency", lat, 2);
      chk("held_req_data", {16'd0, rsp_data}, 32'h0002);
      tick();

      // Reset during cycle 4 of a MUL (RESP in the non-multiply build)
      req_op = 2'b10; req_a = 8'hFF; req_b = 8'hFF;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk_reset_state("abort");
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      req_op = 2'b00; req_a = 8'h01; req_b = 8'h01;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      wait_rsp(lat);
      chk("post_abort_latency", lat, 2);
      chk("post_abort_data", {16'd0, rsp_data}, 32'h0002);
      chk("post_abort_err", {31'd0, rsp_err}, 32'd0);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
